pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised, elastic successor to the fixed ID/EX-style pipeline register: a valid/ready pipeline stage with payload and control fields of configurable width, a 2-entry skid buffer, a synchronous flush that turns in-flight entries into bubbles, and a saturating back-pressure counter. It sits between any two stages of the pipelined CPU core, e.g. ID->EX, EX->MEM or MEM->WB. It sustains one transfer per cycle, and its ready output is not combinationally derived from `out_ready_i`.

## Interface
- `DATA_W`, default 32: payload width (operand data, immediates, register addresses, funct bits).
- `CTRL_W`, default 8: control-signal width (RegWrite, MemRead, ALUOp, ...); forced to zero on bubbles.
- `CNT_W`, default 16: stall-counter width.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  global run enable; low freezes all state.
- `flush_i`  in  1  synchronous flush; kills every held entry.
- `in_valid_i`  in  1  upstream entry valid.
- `in_ready_o`  out  1  stage can accept.
- `in_data_i`  in  DATA_W  upstream payload.
- `in_ctrl_i`  in  CTRL_W  upstream control bits.
- `out_valid_o`  out  1  downstream entry valid.
- `out_ready_i`  in  1  downstream accepts.
- `out_data_o`  out  DATA_W  payload of the head entry.
- `out_ctrl_o`  out  CTRL_W  control bits of the head entry; zero whenever `out_valid_o`=0.
- `stall_cnt_o`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage: main register (head, drives outputs) plus skid register, each with a valid bit.
- States: EMPTY (neither valid), FULL (main only), SKID (both valid).
- Handshake signals:
  - `in_ready_o` = `start_i` & !skid_valid.
  - `out_valid_o` = `start_i` & main_valid.
  - in_fire = `in_valid_i` & `in_ready_o`.
  - out_fire = `out_valid_o` & `out_ready_i`.
- Transitions when `flush_i`=0:
  - EMPTY: in_fire -> FULL, main <= in.
  - FULL, in_fire & out_fire: stay FULL, main <= in.
  - FULL, in_fire & !out_fire: -> SKID, skid <= in.
  - FULL, !in_fire & out_fire: -> EMPTY.
  - SKID, out_fire: -> FULL, main <= skid (no input accepted, since `in_ready_o`=0).
  - Otherwise hold.
- `flush_i`=1 has priority over everything, including `start_i`=0:
  - Next state EMPTY; both valid bits cleared; main and skid ctrl registers cleared to 0.
  - A beat handshaken in the flush cycle is discarded.
  - A beat popped in the flush cycle is still delivered (downstream saw valid & ready).
  - Data registers keep their old contents.
- `start_i`=0 with `flush_i`=0: no register changes, no fires; `in_ready_o`=0 and `out_valid_o`=0, so `out_ctrl_o` reads 0.
- `out_ctrl_o` = main_ctrl when `out_valid_o`=1, else 0.
- `out_data_o` = main_data at all times.
- Order is strictly FIFO; nothing is duplicated or dropped except by flush.
- Stall counter:
  - Increments by 1 each cycle with `out_valid_o`=1 and `out_ready_i`=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by `rst_i`; unaffected by flush.

## Timing
- Reset values: state EMPTY; all data, ctrl and valid registers 0; `stall_cnt_o`=0; `out_valid_o`=0; `out_ctrl_o`=0; `out_data_o`=0. `in_ready_o`=`start_i`.
- Latency: a beat accepted at edge N appears on `out_*` after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle while `out_ready_i`=1.
- Ready timing: `in_ready_o` depends only on registered state and `start_i`. When `out_ready_i` drops, one more beat is absorbed into skid, and `in_ready_o` falls in the next cycle.
- Recovery from SKID: the first pop reloads main from skid; `in_ready_o` rises the cycle after.
- Reset mid-operation: immediate asynchronous return to the reset values; held beats are lost.
- Simultaneous flush and reset: reset wins.

## Test plan
- Streaming: `out_ready_i`=1, push ctrl/data 0x01/0xA0, 0x02/0xA1, 0x03/0xA2 on consecutive cycles -> same sequence out, each 1 cycle later, no gaps, `stall_cnt_o`=0.
- Back-pressure and skid:
  - Push 0xB0, 0xB1, 0xB2 with `out_ready_i`=0 -> `in_ready_o` drops after 2 accepts; 0xB2 is not taken.
  - `stall_cnt_o` counts each held cycle.
  - On releasing ready, output order is 0xB0, 0xB1, then 0xB2 is accepted.
- Flush in SKID state, ctrl 0xFF in both entries -> next cycle `out_valid_o`=0, `out_ctrl_o`=0, `in_ready_o`=1; neither entry ever emerges; counter value retained.
- `start_i`=0 for 3 cycles while FULL with ctrl 0x5A -> `out_valid_o`=0, `out_ctrl_o`=0, no accepts, counter frozen; restoring `start_i` re-presents 0x5A.
- Counter saturation with CNT_W=4: 20 stalled cycles -> `stall_cnt_o`=15.
- Asynchronous `rst_i` pulse between clock edges while in SKID -> outputs immediately at reset values; the next push emerges with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline stage with 2-entry skid buffer, flush and stall counter
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // EMPTY: nothing held, FULL: head only, SKID: head plus overflow entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_valid;
  logic              skid_valid;
  logic              in_fire;
  logic              out_fire;

  // Valid bits are a pure decode of the state register
  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == SKID);

  // Ready depends only on registered state and start, never on out_ready_i
  assign in_ready_o  = start_i & ~skid_valid;
  assign out_valid_o = start_i & main_valid;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  assign out_data_o = main_data;
  assign out_ctrl_o = out_valid_o ? main_ctrl : '0;

  // Occupancy FSM and storage; flush beats everything except reset, and
  // with start_i low both fires are zero so every branch holds
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush_i) begin
      // Bubbles carry zero control; data registers are left as they were
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= FULL;
            main_data <= in_data_i;
            main_ctrl <= in_ctrl_i;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_data <= in_data_i;
            main_ctrl <= in_ctrl_i;
          end else if (in_fire) begin
            state     <= SKID;
            skid_data <= in_data_i;
            skid_ctrl <= in_ctrl_i;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            state     <= FULL;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where a valid head was held back downstream
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_ctrl_i  (in_ctrl),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_ctrl_o (out_ctrl),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of at most two beats
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t             mq[$];
  int                m_cnt;
  logic [DATA_W-1:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cnt  = 0;
      m_data = '0;
    end else begin
      bit ir;
      bit ov;
      ir = start && (mq.size() < 2);
      ov = start && (mq.size() > 0);
      if (ov && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (in_valid && ir) mq.push_back('{c: in_ctrl, d: in_data});
      end
      if (mq.size() > 0) m_data = mq[0].d;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    bit ir;
    bit ov;
    ir = start && (mq.size() < 2);
    ov = start && (mq.size() > 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_ctrl"}, 32'(out_ctrl), ov ? 32'(mq[0].c) : 32'd0);
    chk({tag, ".out_data"}, out_data, m_data);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input logic s, input logic f, input logic iv, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic ordy);
    start = s; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
  endtask

  // Check current outputs against the model, then advance one clock
  task automatic cycle(input string tag);
    #1;
    chk_model(tag);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              s, f, iv;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              e_ir, e_ov;
    logic [CTRL_W-1:0] e_c;
    logic [DATA_W-1:0] e_d;
    int                e_cnt;
  } vec_t;

  vec_t vt[13];

  initial begin
    // streaming, then back-pressure into the skid and release
    vt[0]  = '{1,0,1,8'h01,32'hA0,1, 1,0,8'h00,32'h00,0};
    vt[1]  = '{1,0,1,8'h02,32'hA1,1, 1,1,8'h01,32'hA0,0};
    vt[2]  = '{1,0,1,8'h03,32'hA2,1, 1,1,8'h02,32'hA1,0};
    vt[3]  = '{1,0,0,8'h00,32'h00,1, 1,1,8'h03,32'hA2,0};
    vt[4]  = '{1,0,0,8'h00,32'h00,1, 1,0,8'h00,32'hA2,0};
    vt[5]  = '{1,0,1,8'h10,32'hB0,0, 1,0,8'h00,32'hA2,0};
    vt[6]  = '{1,0,1,8'h11,32'hB1,0, 1,1,8'h10,32'hB0,0};
    vt[7]  = '{1,0,1,8'h12,32'hB2,0, 0,1,8'h10,32'hB0,1};
    vt[8]  = '{1,0,1,8'h12,32'hB2,0, 0,1,8'h10,32'hB0,2};
    vt[9]  = '{1,0,1,8'h12,32'hB2,1, 0,1,8'h10,32'hB0,3};
    vt[10] = '{1,0,1,8'h12,32'hB2,1, 1,1,8'h11,32'hB1,3};
    vt[11] = '{1,0,0,8'h00,32'h00,1, 1,1,8'h12,32'hB2,3};
    vt[12] = '{1,0,0,8'h00,32'h00,1, 1,0,8'h00,32'hB2,3};

    rst = 1'b1;
    drive(1, 0, 0, '0, '0, 1);
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].s, vt[i].f, vt[i].iv, vt[i].c, vt[i].d, vt[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d.out_ctrl", i), 32'(out_ctrl), 32'(vt[i].e_c));
      chk($sformatf("vec%0d.out_data", i), out_data, vt[i].e_d);
      chk($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(vt[i].e_cnt));
      @(posedge clk);
      #1;
    end

    // flush while in SKID with all-ones control in both entries
    drive(1, 0, 1, 8'hFF, 32'hC0, 0); cycle("fl_push0");
    drive(1, 0, 1, 8'hFF, 32'hC1, 0); cycle("fl_push1");
    drive(1, 1, 1, 8'hFF, 32'hC2, 0); cycle("fl_flush");
    drive(1, 0, 0, '0, '0, 1);
    #1;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.out_ctrl", 32'(out_ctrl), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    chk("flush.stall_cnt", 32'(stall_cnt), 32'd5);
    for (int i = 0; i < 3; i++) cycle("fl_drain");

    // start low freezes a FULL stage
    drive(1, 0, 1, 8'h5A, 32'hD0, 0); cycle("st_push");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'h33, 32'hD1, 0);
      #1;
      chk("stop.out_valid", 32'(out_valid), 32'd0);
      chk("stop.out_ctrl", 32'(out_ctrl), 32'd0);
      chk("stop.in_ready", 32'(in_ready), 32'd0);
      cycle("st_off");
    end
    drive(1, 0, 0, '0, '0, 1);
    #1;
    chk("restart.out_ctrl", 32'(out_ctrl), 32'h5A);
    chk("restart.out_data", out_data, 32'hD0);
    cycle("st_on");
    cycle("st_idle");

    // saturation: 20 held cycles on a 4-bit counter
    rst = 1'b1; #2 rst = 1'b0;
    drive(1, 0, 1, 8'h44, 32'hE0, 0); cycle("sat_push");
    drive(1, 0, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) cycle("sat_hold");
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd15);

    // asynchronous reset between edges while in SKID
    drive(1, 0, 1, 8'h61, 32'hF0, 0); cycle("ar_push");
    drive(1, 0, 0, '0, '0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_ctrl", 32'(out_ctrl), 32'd0);
    chk("arst.out_data", out_data, 32'd0);
    chk("arst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 0, 1, 8'h77, 32'hF7, 1); cycle("ar_repush");
    drive(1, 0, 0, '0, '0, 1);
    #1;
    chk("arst.lat_valid", 32'(out_valid), 32'd1);
    chk("arst.lat_data", out_data, 32'hF7);
    cycle("ar_pop");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
            CTRL_W'($urandom), $urandom, 1'($urandom));
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
